// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the multi-cycle RV32I-subset control path:
// opcode / funct3 constants, sequencer state and instruction-class enums,
// and the datapath select encodings, which match the single-cycle decoder.
// -----------------------------------------------------------------------------
package core_pkg;

  // Supported major opcodes (IR[6:0])
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_CALCI  = 7'b0010011;
  localparam logic [6:0] OP_CALC   = 7'b0110011;

  // The only ALU funct3 values this core executes
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;

  // pc_src
  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  // memtoreg
  localparam logic [1:0] WB_ALU   = 2'b00;
  localparam logic [1:0] WB_MEM   = 2'b01;
  localparam logic [1:0] WB_PC4   = 2'b10;
  localparam logic [1:0] WB_PCIMM = 2'b11;

  // aluop
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_SLT = 2'b10;

  // err_code
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, TRAP
  } state_t;

  typedef enum logic [3:0] {
    IC_LUI, IC_AUIPC, IC_JAL, IC_JALR, IC_BRANCH,
    IC_LOAD, IC_STORE, IC_CALCI, IC_CALC
  } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// -----------------------------------------------------------------------------
// mc_decode
// Combinational classifier: opcode/funct3 -> instruction class + illegal flag.
// Ports:
//   i_opcode  [6:0]  IR[6:0]
//   i_funct3  [2:0]  IR[14:12]
//   o_iclass         instruction class (don't-care when o_illegal)
//   o_illegal        opcode unsupported, or CALC/CALCI funct3 not ADD/SLT
// -----------------------------------------------------------------------------
module mc_decode
  import core_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  output iclass_t    o_iclass,
  output logic       o_illegal
);

  logic w_f3_ok;
  assign w_f3_ok = (i_funct3 == F3_ADD) || (i_funct3 == F3_SLT);

  // NOTE: every output gets a default before the case, so no path through
  // the block leaves a variable unassigned and no latch is inferred.
  always_comb begin
    o_iclass  = IC_LUI;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_LUI:    o_iclass = IC_LUI;
      OP_AUIPC:  o_iclass = IC_AUIPC;
      OP_JAL:    o_iclass = IC_JAL;
      OP_JALR:   o_iclass = IC_JALR;
      OP_BRANCH: o_iclass = IC_BRANCH;
      OP_LOAD:   o_iclass = IC_LOAD;
      OP_STORE:  o_iclass = IC_STORE;
      OP_CALCI: begin
        o_iclass  = IC_CALCI;
        o_illegal = !w_f3_ok;
      end
      OP_CALC: begin
        o_iclass  = IC_CALC;
        o_illegal = !w_f3_ok;
      end
      default:   o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// -----------------------------------------------------------------------------
// multi_cycle_control
// FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I-subset core with one shared
// memory port. Sticky TRAP on illegal instruction or memory timeout.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   opcode, funct3            IR fields, valid from DECODE onward
//   br_taken                  ALU branch condition, valid in EXEC
//   mem_ready                 memory completes current access this cycle
//   mem_req/mem_we/mem_sel    memory request, write strobe, address select
//   ir_write, pc_write        IR / PC load strobes (completing cycle only)
//   pc_src, memtoreg          PC and write-back selects
//   aluop, alusrc0, alusrc1   ALU operation and operand selects
//   regwrite                  register file write enable
//   halted, err_code          in TRAP, sticky trap cause
//   retire_cnt                instructions retired since reset (wraps)
// -----------------------------------------------------------------------------
module multi_cycle_control
  import core_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             br_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_sel,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [1:0]       memtoreg,
  output logic [1:0]       aluop,
  output logic             alusrc0,
  output logic             alusrc1,
  output logic             regwrite,
  output logic             halted,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] retire_cnt
);

  // Wait counter only ever holds 0 .. MEM_TIMEOUT-1
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t            r_state;
  iclass_t           r_class;
  logic              r_slt;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_retire;
  logic [1:0]        r_err;

  iclass_t     w_class;
  logic        w_illegal;
  logic        w_waiting;
  logic        w_timeout;
  logic        w_retire;
  logic [1:0]  w_aluop;
  logic        w_src0;
  logic        w_src1;

  mc_decode u_decode (
    .i_opcode  (opcode),
    .i_funct3  (funct3),
    .o_iclass  (w_class),
    .o_illegal (w_illegal)
  );

  // A memory phase that has not completed this cycle; the last allowed
  // cycle still completes if mem_ready arrives in it.
  assign w_waiting = ((r_state == FETCH) || (r_state == MEM)) && !mem_ready;
  assign w_timeout = w_waiting && (r_wait == WAIT_W'(MEM_TIMEOUT - 1));

  // ALU controls depend only on the latched class, so EXEC and the following
  // MEM/WB see identical operands.
  always_comb begin
    w_aluop = ALU_ADD;
    w_src0  = 1'b0;
    w_src1  = 1'b0;
    case (r_class)
      IC_LUI: begin
        w_src0 = 1'b1;                      // zero + imm
        w_src1 = 1'b1;
      end
      IC_LOAD, IC_STORE, IC_JALR: w_src1 = 1'b1;
      IC_CALCI: begin
        w_src1  = 1'b1;
        w_aluop = r_slt ? ALU_SLT : ALU_ADD;
      end
      IC_CALC:   w_aluop = r_slt ? ALU_SLT : ALU_ADD;
      IC_BRANCH: w_aluop = ALU_SUB;
      default: ;
    endcase
  end

  // Output decode from the registered state. Gated by rstn so every strobe
  // (mem_req included) is low while reset is held and drops the instant it
  // is asserted.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_sel  = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_src   = PC_PLUS4;
    memtoreg = WB_ALU;
    aluop    = ALU_ADD;
    alusrc0  = 1'b0;
    alusrc1  = 1'b0;
    regwrite = 1'b0;
    halted   = 1'b0;
    w_retire = 1'b0;
    if (rstn) begin
      case (r_state)
        FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ready;
        end
        EXEC: begin
          aluop   = w_aluop;
          alusrc0 = w_src0;
          alusrc1 = w_src1;
          case (r_class)
            IC_BRANCH: begin
              pc_write = 1'b1;
              pc_src   = br_taken ? PC_IMM : PC_PLUS4;
              w_retire = 1'b1;
            end
            IC_JAL: begin
              regwrite = 1'b1;
              memtoreg = WB_PC4;
              pc_write = 1'b1;
              pc_src   = PC_IMM;
              w_retire = 1'b1;
            end
            IC_JALR: begin
              regwrite = 1'b1;
              memtoreg = WB_PC4;
              pc_write = 1'b1;
              pc_src   = PC_ALU;
              w_retire = 1'b1;
            end
            default: ;
          endcase
        end
        MEM: begin
          mem_req = 1'b1;
          mem_sel = 1'b1;
          mem_we  = (r_class == IC_STORE);
          aluop   = w_aluop;
          alusrc0 = w_src0;
          alusrc1 = w_src1;
          if (mem_ready && (r_class == IC_STORE)) begin
            pc_write = 1'b1;
            w_retire = 1'b1;
          end
        end
        WB: begin
          aluop    = w_aluop;
          alusrc0  = w_src0;
          alusrc1  = w_src1;
          regwrite = 1'b1;
          pc_write = 1'b1;
          w_retire = 1'b1;
          if (r_class == IC_LOAD)       memtoreg = WB_MEM;
          else if (r_class == IC_AUIPC) memtoreg = WB_PCIMM;
        end
        TRAP:    halted = 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= FETCH;
      r_class  <= IC_LUI;
      r_slt    <= 1'b0;
      r_wait   <= '0;
      r_retire <= '0;
      r_err    <= ERR_NONE;
    end else begin
      if (w_retire) r_retire <= r_retire + CNT_W'(1);
      // Count only while stalled in a memory phase; any state change clears it.
      r_wait <= (w_waiting && !w_timeout) ? r_wait + WAIT_W'(1) : '0;
      case (r_state)
        FETCH: begin
          if (mem_ready) r_state <= DECODE;
          else if (w_timeout) begin
            r_state <= TRAP;
            r_err   <= ERR_TIMEOUT;
          end
        end
        DECODE: begin
          r_class <= w_class;
          r_slt   <= (funct3 == F3_SLT);
          if (w_illegal) begin
            r_state <= TRAP;
            r_err   <= ERR_ILLEGAL;
          end else begin
            r_state <= EXEC;
          end
        end
        EXEC: begin
          case (r_class)
            IC_BRANCH, IC_JAL, IC_JALR: r_state <= FETCH;
            IC_LOAD, IC_STORE:          r_state <= MEM;
            default:                    r_state <= WB;
          endcase
        end
        MEM: begin
          if (mem_ready) r_state <= (r_class == IC_LOAD) ? WB : FETCH;
          else if (w_timeout) begin
            r_state <= TRAP;
            r_err   <= ERR_TIMEOUT;
          end
        end
        WB:      r_state <= FETCH;
        default: r_state <= TRAP;           // TRAP is left only through rstn
      endcase
    end
  end

  assign err_code   = r_err;
  assign retire_cnt = r_retire;

endmodule

// File: tb/tb_multi_cycle_control.sv
// -----------------------------------------------------------------------------
// tb_multi_cycle_control
// Directed bench for multi_cycle_control. Two instances share all inputs:
// u_dut (CNT_W=32) and u_dut_w (CNT_W=3, exercises counter wrap), both with
// MEM_TIMEOUT=4. Strobes are packed as
// {mem_req,mem_we,mem_sel,ir_write,pc_write,pc_src,memtoreg,aluop,
//  alusrc0,alusrc1,regwrite,halted}.
// -----------------------------------------------------------------------------
module tb_multi_cycle_control;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       br_taken = 1'b0;
  logic       mem_ready = 1'b0;

  logic        mem_req, mem_we, mem_sel, ir_write, pc_write, alusrc0, alusrc1, regwrite, halted;
  logic [1:0]  pc_src, memtoreg, aluop, err_code;
  logic [31:0] retire_cnt;

  logic        b_mem_req, b_mem_we, b_mem_sel, b_ir_write, b_pc_write, b_alusrc0, b_alusrc1;
  logic        b_regwrite, b_halted;
  logic [1:0]  b_pc_src, b_memtoreg, b_aluop, b_err_code;
  logic [2:0]  b_retire_cnt;

  logic [14:0] obs, obs_b;
  assign obs   = {mem_req, mem_we, mem_sel, ir_write, pc_write, pc_src, memtoreg, aluop,
                  alusrc0, alusrc1, regwrite, halted};
  assign obs_b = {b_mem_req, b_mem_we, b_mem_sel, b_ir_write, b_pc_write, b_pc_src, b_memtoreg,
                  b_aluop, b_alusrc0, b_alusrc1, b_regwrite, b_halted};

  // Expected strobe vectors
  localparam logic [14:0] V_IDLE       = 15'b0_0_0_0_0_00_00_00_0_0_0_0;
  localparam logic [14:0] V_FETCH_WAIT = 15'b1_0_0_0_0_00_00_00_0_0_0_0;
  localparam logic [14:0] V_FETCH_DONE = 15'b1_0_0_1_0_00_00_00_0_0_0_0;
  localparam logic [14:0] V_TRAP       = 15'b0_0_0_0_0_00_00_00_0_0_0_1;
  localparam logic [14:0] V_ADDR       = 15'b0_0_0_0_0_00_00_00_0_1_0_0;
  localparam logic [14:0] V_ADDI_WB    = 15'b0_0_0_0_1_00_00_00_0_1_1_0;
  localparam logic [14:0] V_LD_MEM     = 15'b1_0_1_0_0_00_00_00_0_1_0_0;
  localparam logic [14:0] V_LD_WB      = 15'b0_0_0_0_1_00_01_00_0_1_1_0;
  localparam logic [14:0] V_ST_WAIT    = 15'b1_1_1_0_0_00_00_00_0_1_0_0;
  localparam logic [14:0] V_ST_DONE    = 15'b1_1_1_0_1_00_00_00_0_1_0_0;
  localparam logic [14:0] V_BEQ_T      = 15'b0_0_0_0_1_01_00_01_0_0_0_0;
  localparam logic [14:0] V_BEQ_NT     = 15'b0_0_0_0_1_00_00_01_0_0_0_0;
  localparam logic [14:0] V_JAL        = 15'b0_0_0_0_1_01_10_00_0_0_1_0;
  localparam logic [14:0] V_JALR       = 15'b0_0_0_0_1_10_10_00_0_1_1_0;
  localparam logic [14:0] V_SLT_EX     = 15'b0_0_0_0_0_00_00_10_0_0_0_0;
  localparam logic [14:0] V_SLT_WB     = 15'b0_0_0_0_1_00_00_10_0_0_1_0;
  localparam logic [14:0] V_LUI_EX     = 15'b0_0_0_0_0_00_00_00_1_1_0_0;
  localparam logic [14:0] V_LUI_WB     = 15'b0_0_0_0_1_00_00_00_1_1_1_0;
  localparam logic [14:0] V_AUIPC_WB   = 15'b0_0_0_0_1_00_11_00_0_0_1_0;

  int n_checks   = 0;
  int n_fail     = 0;
  int exp_retire = 0;

  multi_cycle_control #(.MEM_TIMEOUT(4), .CNT_W(32)) u_dut (
    .clk(clk), .rstn(rstn), .opcode(opcode), .funct3(funct3), .br_taken(br_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .memtoreg(memtoreg),
    .aluop(aluop), .alusrc0(alusrc0), .alusrc1(alusrc1), .regwrite(regwrite),
    .halted(halted), .err_code(err_code), .retire_cnt(retire_cnt)
  );

  multi_cycle_control #(.MEM_TIMEOUT(4), .CNT_W(3)) u_dut_w (
    .clk(clk), .rstn(rstn), .opcode(opcode), .funct3(funct3), .br_taken(br_taken),
    .mem_ready(mem_ready), .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_sel(b_mem_sel),
    .ir_write(b_ir_write), .pc_write(b_pc_write), .pc_src(b_pc_src), .memtoreg(b_memtoreg),
    .aluop(b_aluop), .alusrc0(b_alusrc0), .alusrc1(b_alusrc1), .regwrite(b_regwrite),
    .halted(b_halted), .err_code(b_err_code), .retire_cnt(b_retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Assert reset mid-cycle, hold it across one edge, release after the edge.
  task automatic do_reset();
    rstn = 1'b0;
    #1;
    check("rst_strobes", obs, V_IDLE);
    check("rst_strobes_w", obs_b, V_IDLE);
    check("rst_err", err_code, 2'b00);
    check("rst_retire", retire_cnt, 0);
    check("rst_retire_w", b_retire_cnt, 0);
    exp_retire = 0;
    step();
    rstn = 1'b1;
  endtask

  // FETCH with immediate ready, then DECODE; leaves the bench in the cycle after DECODE.
  task automatic fetch_decode(input logic [6:0] op, input logic [2:0] f3, input string tag);
    opcode    = op;
    funct3    = f3;
    mem_ready = 1'b1;
    br_taken  = 1'b0;
    settle();
    check({tag, "_fetch"}, obs, V_FETCH_DONE);
    step();
    settle();
    check({tag, "_decode"}, obs, V_IDLE);
    step();
  endtask

  task automatic check_retire(input string tag);
    check({tag, "_retire"}, retire_cnt, exp_retire);
    check({tag, "_retire_w"}, b_retire_cnt, exp_retire & 7);
  endtask

  // Non-memory instruction: EXEC, optional WB, then one retire.
  task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input logic br,
                          input logic [14:0] e_exec, input logic has_wb,
                          input logic [14:0] e_wb, input string tag);
    fetch_decode(op, f3, tag);
    br_taken = br;
    settle();
    check({tag, "_exec"}, obs, e_exec);
    check({tag, "_exec_w"}, obs_b, e_exec);
    if (has_wb) begin
      step();
      settle();
      check({tag, "_wb"}, obs, e_wb);
    end
    step();
    exp_retire++;
    settle();
    check_retire(tag);
  endtask

  initial begin
    // Reset state
    #3;
    do_reset();
    mem_ready = 1'b0;
    settle();
    check("fetch_after_rst", obs, V_FETCH_WAIT);

    // ADDI x1,x0,5: FETCH, DECODE, EXEC, WB
    do_instr(7'b0010011, 3'b000, 1'b0, V_ADDR, 1'b1, V_ADDI_WB, "addi");

    // LW with mem_ready arriving on the 4th MEM cycle
    fetch_decode(7'b0000011, 3'b010, "lw");
    settle();
    check("lw_exec", obs, V_ADDR);
    mem_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      settle();
      check("lw_mem_wait", obs, V_LD_MEM);
      step();
    end
    mem_ready = 1'b1;
    settle();
    check("lw_mem_done", obs, V_LD_MEM);
    step();
    settle();
    check("lw_wb", obs, V_LD_WB);
    step();
    exp_retire++;
    settle();
    check_retire("lw");

    // SW with immediate ready
    fetch_decode(7'b0100011, 3'b010, "sw");
    settle();
    check("sw_exec", obs, V_ADDR);
    step();
    settle();
    check("sw_mem", obs, V_ST_DONE);
    step();
    exp_retire++;
    settle();
    check_retire("sw");

    do_instr(7'b1100011, 3'b000, 1'b1, V_BEQ_T,  1'b0, V_IDLE,     "beq_t");
    do_instr(7'b1100011, 3'b000, 1'b0, V_BEQ_NT, 1'b0, V_IDLE,     "beq_nt");
    do_instr(7'b1101111, 3'b000, 1'b0, V_JAL,    1'b0, V_IDLE,     "jal");
    do_instr(7'b1100111, 3'b000, 1'b0, V_JALR,   1'b0, V_IDLE,     "jalr");
    do_instr(7'b0110011, 3'b010, 1'b0, V_SLT_EX, 1'b1, V_SLT_WB,   "slt");   // 8th: wraps CNT_W=3
    do_instr(7'b0110111, 3'b000, 1'b0, V_LUI_EX, 1'b1, V_LUI_WB,   "lui");
    do_instr(7'b0010111, 3'b000, 1'b0, V_IDLE,   1'b1, V_AUIPC_WB, "auipc");

    // Unsupported opcode (SYSTEM) -> sticky TRAP(01)
    fetch_decode(7'b1110011, 3'b000, "ecall");
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      settle();
      check("ecall_trap", obs, V_TRAP);
      check("ecall_err", err_code, 2'b01);
      step();
    end
    check_retire("ecall");

    // CALCI with unsupported funct3 -> TRAP(01)
    do_reset();
    fetch_decode(7'b0010011, 3'b001, "slli");
    settle();
    check("slli_trap", obs, V_TRAP);
    check("slli_err", err_code, 2'b01);

    // FETCH timeout: 4 cycles without ready -> TRAP(10)
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("fetch_wait", obs, V_FETCH_WAIT);
      step();
    end
    settle();
    check("fetch_to_trap", obs, V_TRAP);
    check("fetch_to_err", err_code, 2'b10);
    check("fetch_to_err_w", b_err_code, 2'b10);

    // Ready on the final allowed FETCH cycle completes normally
    do_reset();
    opcode    = 7'b0010011;
    funct3    = 3'b000;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("fetch_late_wait", obs, V_FETCH_WAIT);
      step();
    end
    mem_ready = 1'b1;
    settle();
    check("fetch_late_done", obs, V_FETCH_DONE);
    step();
    settle();
    check("fetch_late_decode", obs, V_IDLE);
    check("fetch_late_err", err_code, 2'b00);
    step();
    settle();
    check("fetch_late_exec", obs, V_ADDR);

    // MEM timeout on a load -> TRAP(10)
    do_reset();
    fetch_decode(7'b0000011, 3'b010, "lw_to");
    mem_ready = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      settle();
      check("lw_to_wait", obs, V_LD_MEM);
      step();
    end
    settle();
    check("lw_to_trap", obs, V_TRAP);
    check("lw_to_err", err_code, 2'b10);

    // Reset pulsed during MEM of a stalled SW
    do_reset();
    do_instr(7'b0010011, 3'b000, 1'b0, V_ADDR, 1'b1, V_ADDI_WB, "addi2");
    fetch_decode(7'b0100011, 3'b010, "sw_rst");
    mem_ready = 1'b0;
    step();
    settle();
    check("sw_rst_mem", obs, V_ST_WAIT);
    step();
    settle();
    check("sw_rst_mem2", obs, V_ST_WAIT);
    do_reset();
    settle();
    check("sw_rst_fetch", obs, V_FETCH_WAIT);
    check("sw_rst_err", err_code, 2'b00);
    check("sw_rst_retire", retire_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
